// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Holds the fetch FSM encoding and the word-alignment helper used on redirect targets.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory read port: registered request/address from fetch, ack/data back.
// A zero-wait memory may raise imem_ack in the same cycle it sees imem_req.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_buf.sv
// Two-entry {pc, inst} FIFO kept as a shift pair: entry 0 is always the head.
// The head entry keeps its contents after the last pop so pc_IF holds its value when empty.
module fetch_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_inst,
    output logic [1:0]  count,
    output logic [31:0] head_pc,
    output logic [31:0] head_inst
);

    logic [1:0]  cnt_p0;
    logic [31:0] e0_pc_p0, e0_inst_p0, e1_pc_p0, e1_inst_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0     <= 2'd0;
            e0_pc_p0   <= 32'h0;
            e0_inst_p0 <= 32'h0;
            e1_pc_p0   <= 32'h0;
            e1_inst_p0 <= 32'h0;
        end else if (flush) begin
            cnt_p0 <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    cnt_p0 <= cnt_p0 + 2'd1;
                    if (cnt_p0 == 2'd0) begin
                        e0_pc_p0   <= push_pc;
                        e0_inst_p0 <= push_inst;
                    end else begin
                        e1_pc_p0   <= push_pc;
                        e1_inst_p0 <= push_inst;
                    end
                end
                2'b01: begin
                    cnt_p0 <= cnt_p0 - 2'd1;
                    if (cnt_p0 == 2'd2) begin
                        e0_pc_p0   <= e1_pc_p0;
                        e0_inst_p0 <= e1_inst_p0;
                    end
                end
                2'b11: begin
                    // Count unchanged; the new entry lands behind whatever survives the pop.
                    if (cnt_p0 == 2'd2) begin
                        e0_pc_p0   <= e1_pc_p0;
                        e0_inst_p0 <= e1_inst_p0;
                        e1_pc_p0   <= push_pc;
                        e1_inst_p0 <= push_inst;
                    end else begin
                        e0_pc_p0   <= push_pc;
                        e0_inst_p0 <= push_inst;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count     = cnt_p0;
    assign head_pc   = e0_pc_p0;
    assign head_inst = e0_inst_p0;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem read in flight,
// buffers up to two instructions and presents the head (or a NOP bubble) to if_id.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    if_fetch_if.master  imem,
    output logic        IF_valid,
    output logic [31:0] pc_IF,
    output logic [31:0] IF_pc4,
    output logic [31:0] IF_inst
);

    fetch_state_t state_p0, state_nxt;
    logic [31:0]  fetch_pc_p0, fetch_pc_nxt;
    logic [31:0]  addr_p0, addr_nxt;
    logic         req_p0;
    logic         push, pop;
    logic [1:0]   count;
    logic [2:0]   occ_after;
    logic [31:0]  head_pc, head_inst, tgt, pc_inc;

    assign tgt       = word_align(redirect_pc);
    assign pc_inc    = fetch_pc_p0 + 32'd4;
    assign pop       = IF_valid & ~stall & ~redirect_en;
    assign occ_after = {1'b0, count} + 3'd1 - {2'b00, pop};

    always_comb begin
        state_nxt    = state_p0;
        fetch_pc_nxt = fetch_pc_p0;
        addr_nxt     = addr_p0;
        push         = 1'b0;
        case (state_p0)
            IDLE: begin
                if (redirect_en) begin
                    fetch_pc_nxt = tgt;
                end else if (count < 2'd2) begin
                    state_nxt = WAIT;
                    addr_nxt  = fetch_pc_p0;
                end
            end
            WAIT: begin
                if (imem.imem_ack) begin
                    if (redirect_en) begin
                        fetch_pc_nxt = tgt;
                        addr_nxt     = tgt;
                    end else begin
                        push         = 1'b1;
                        fetch_pc_nxt = pc_inc;
                        // Issue back-to-back only if a buffer slot stays free for the reply.
                        if (occ_after < 3'd2) addr_nxt  = pc_inc;
                        else                  state_nxt = IDLE;
                    end
                end else if (redirect_en) begin
                    fetch_pc_nxt = tgt;
                    state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect_en) fetch_pc_nxt = tgt;
                if (imem.imem_ack) begin
                    state_nxt = WAIT;
                    addr_nxt  = redirect_en ? tgt : fetch_pc_p0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0    <= IDLE;
            fetch_pc_p0 <= RESET_PC;
            addr_p0     <= 32'h0;
            req_p0      <= 1'b0;
        end else begin
            state_p0    <= state_nxt;
            fetch_pc_p0 <= fetch_pc_nxt;
            addr_p0     <= addr_nxt;
            req_p0      <= (state_nxt != IDLE);
        end
    end

    assign imem.imem_req  = req_p0;
    assign imem.imem_addr = addr_p0;

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_en),
        .push_pc   (addr_p0),
        .push_inst (imem.imem_rdata),
        .count     (count),
        .head_pc   (head_pc),
        .head_inst (head_inst)
    );

    assign IF_valid = (count != 2'd0);
    assign pc_IF    = head_pc;
    assign IF_pc4   = head_pc + 32'd4;
    assign IF_inst  = IF_valid ? head_inst : NOP_INST;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a latency-programmable imem model, directed phases, and a
// scoreboard monitor that checks every instruction consumed by if_id against a queue.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_en;
  logic [31:0] redirect_pc;
  logic        IF_valid;
  logic [31:0] pc_IF, IF_pc4, IF_inst;
  int unsigned mem_lat, lat_cnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  if_fetch_if bus();

  if_fetch #(.RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .IF_valid    (IF_valid),
    .pc_IF       (pc_IF),
    .IF_pc4      (IF_pc4),
    .IF_inst     (IF_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ({a[15:0], a[31:16]} ^ ~a) + 32'h13;
  endfunction

  // imem model: acks once the request has been seen for mem_lat cycles
  assign bus.imem_ack   = bus.imem_req && (lat_cnt >= mem_lat);
  assign bus.imem_rdata = inst_of(bus.imem_addr);

  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ack) lat_cnt <= 0;
    else                                      lat_cnt <= lat_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, inst: inst_of(pc)});
  endtask

  task automatic do_reset(input logic stall_after);
    stall = 1'b1;
    redirect_en = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    stall = stall_after;
  endtask

  task automatic drain_and_hold();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    stall = 1'b1;
  endtask

  // Scoreboard monitor: inputs only change just after posedge, so the values seen
  // here decide whether the head is consumed at the next edge.
  always @(negedge clk) begin
    if (!rst && IF_valid && !stall && !redirect_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", pc_IF, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", pc_IF, e.pc);
        chk("sb_pc4", IF_pc4, e.pc + 32'd4);
        chk("sb_inst", IF_inst, e.inst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0; mem_lat = 0;

    // Reset, zero-wait streaming, stall back-pressure
    tick();
    tick();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", IF_valid, 0);
    chk("rst_inst", IF_inst, 32'h0);
    chk("rst_pc", pc_IF, 32'h0);
    chk("rst_pc4", IF_pc4, 32'h4);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10);
    rst = 1'b0; stall = 1'b0;
    tick();
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    chk("first_valid_early", IF_valid, 0);
    tick();
    chk("first_valid", IF_valid, 1);
    chk("first_pc", pc_IF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (IF_valid && pc_IF == 32'h8) break;
      tick();
    end
    chk("reach_pc8", pc_IF, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_req_drop", bus.imem_req, 0);
    chk("stall_head", pc_IF, 32'h8);
    chk("stall_valid", IF_valid, 1);
    stall = 1'b0;
    drain_and_hold();

    // Redirect while a slow request to 0x10 is outstanding
    mem_lat = 3;
    do_reset(1'b0);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'h100); push_exp(32'h104);
    for (int i = 0; i < 60; i++) begin
      if (bus.imem_req && bus.imem_addr == 32'h10) break;
      tick();
    end
    chk("pending_addr", bus.imem_addr, 32'h10);
    redirect_en = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_addr", bus.imem_addr, 32'h10);
      chk("drain_req", bus.imem_req, 1);
      chk("drain_valid", IF_valid, 0);
      chk("drain_inst", IF_inst, 32'h0);
      tick();
    end
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_req", bus.imem_req, 1);
    drain_and_hold();

    // Redirect together with stall and ack, then with two entries buffered
    mem_lat = 0;
    do_reset(1'b1);
    tick();
    chk("c_req", bus.imem_req, 1);
    chk("c_addr0", bus.imem_addr, 32'h0);
    tick();
    chk("c_valid", IF_valid, 1);
    chk("c_addr4", bus.imem_addr, 32'h4);
    redirect_en = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_en = 1'b0;
    chk("c_ack_flush_valid", IF_valid, 0);
    chk("c_ack_flush_addr", bus.imem_addr, 32'h200);
    tick();
    tick();
    chk("c_full_req", bus.imem_req, 0);
    chk("c_full_head", pc_IF, 32'h200);
    redirect_en = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_en = 1'b0;
    chk("c_flush2_valid", IF_valid, 0);
    chk("c_flush2_inst", IF_inst, 32'h0);
    push_exp(32'h100); push_exp(32'h104);
    stall = 1'b0;
    drain_and_hold();

    // Misaligned redirect target and PC wrap-around
    do_reset(1'b0);
    push_exp(32'h100); push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
    tick();
    redirect_en = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_en = 1'b0;
    chk("align_addr", bus.imem_addr, 32'h100);
    chk("align_valid", IF_valid, 0);
    tick();
    tick();
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_valid", IF_valid, 0);
    tick();
    chk("wrap_pc", pc_IF, 32'hFFFF_FFFC);
    chk("wrap_pc4", IF_pc4, 32'h0);
    drain_and_hold();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
